// File: rtl/dmem_atomic_responder.sv
// dmem_atomic_responder
// Data-memory responder between the pipeline memory stage and the memory
// controller. Serves LW/SW/LL/SC requests with wait states, returns a
// one-cycle dhit pulse with registered load data, and owns the LL/SC link
// register (reservation, store-conditional check, invalidation).
module dmem_atomic_responder #(
    parameter int ADDR_W = 32,
    parameter int WORD_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              dmemREN,
    input  logic              dmemWEN,
    input  logic              datomic,
    input  logic [ADDR_W-1:0] dmemaddr,
    input  logic [WORD_W-1:0] dmemstore,
    output logic              dhit,
    output logic [WORD_W-1:0] dmemload,
    output logic              dREN,
    output logic              dWEN,
    output logic [ADDR_W-1:0] daddr,
    output logic [WORD_W-1:0] dstore,
    input  logic [WORD_W-1:0] dload,
    input  logic              dwait,
    input  logic              ccinv,
    input  logic [ADDR_W-1:0] ccsnoopaddr,
    input  logic              halt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Word-granular mask: the two byte-offset bits never take part in a match.
    localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};
    localparam logic [WORD_W-1:0] WORD_ZERO = {WORD_W{1'b0}};
    localparam logic [WORD_W-1:0] WORD_ONE  = {{(WORD_W-1){1'b0}}, 1'b1};

    // Two byte addresses refer to the same word.
    function automatic logic word_match(input logic [ADDR_W-1:0] a,
                                        input logic [ADDR_W-1:0] b);
        return (((a ^ b) & WORD_MASK) == {ADDR_W{1'b0}});
    endfunction

    state_t              state_r;
    state_t              state_nxt_s;

    logic [ADDR_W-1:0]   req_addr_r;
    logic [WORD_W-1:0]   req_store_r;
    logic                req_atomic_r;
    logic                sc_flag_r;

    logic                link_valid_r;
    logic [ADDR_W-1:0]   link_addr_r;
    logic                link_valid_nxt_s;
    logic [ADDR_W-1:0]   link_addr_nxt_s;

    logic                dhit_r;
    logic [WORD_W-1:0]   dmemload_r;
    logic                dren_r;
    logic                dwen_r;
    logic [ADDR_W-1:0]   daddr_r;
    logic [WORD_W-1:0]   dstore_r;

    logic                dhit_nxt_s;
    logic [WORD_W-1:0]   dmemload_nxt_s;
    logic                dren_nxt_s;
    logic                dwen_nxt_s;
    logic [ADDR_W-1:0]   daddr_nxt_s;
    logic [WORD_W-1:0]   dstore_nxt_s;

    logic                req_wr_s;
    logic                sc_ok_s;
    logic                launch_s;
    logic                ll_done_s;
    logic                store_kill_s;
    logic [ADDR_W-1:0]   addr_sel_s;
    logic [WORD_W-1:0]   store_sel_s;

    // Decode of the incoming request while idle; a read always beats a write.
    always_comb begin
        req_wr_s = dmemWEN & ~dmemREN;
        sc_ok_s  = req_wr_s & datomic & link_valid_r & word_match(dmemaddr, link_addr_r);
        launch_s = (state_r == ST_IDLE) && (state_nxt_s != ST_IDLE);
        if (state_r == ST_IDLE) begin
            addr_sel_s  = dmemaddr;
            store_sel_s = dmemstore;
        end else begin
            addr_sel_s  = req_addr_r;
            store_sel_s = req_store_r;
        end
    end

    // State register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (dmemREN) begin
                    state_nxt_s = ST_READ;
                end else if (dmemWEN) begin
                    if (!datomic || sc_ok_s) begin
                        state_nxt_s = ST_WRITE;
                    end else begin
                        state_nxt_s = ST_RESP;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_READ: begin
                if (!dwait) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_READ;
                end
            end
            ST_WRITE: begin
                if (!dwait) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_WRITE;
                end
            end
            ST_RESP: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Latch the request fields when leaving IDLE; they stay fixed for the access.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            req_addr_r   <= {ADDR_W{1'b0}};
            req_store_r  <= {WORD_W{1'b0}};
            req_atomic_r <= 1'b0;
            sc_flag_r    <= 1'b0;
        end else if (launch_s) begin
            req_addr_r   <= dmemaddr;
            req_store_r  <= dmemstore;
            req_atomic_r <= datomic;
            sc_flag_r    <= sc_ok_s;
        end
    end

    // Output logic: next values of the registered outputs, derived from the next state.
    always_comb begin
        dren_nxt_s     = (state_nxt_s == ST_READ);
        dwen_nxt_s     = (state_nxt_s == ST_WRITE);
        dhit_nxt_s     = (state_nxt_s == ST_RESP);
        daddr_nxt_s    = daddr_r;
        dstore_nxt_s   = dstore_r;
        dmemload_nxt_s = dmemload_r;
        if ((state_nxt_s == ST_READ) || (state_nxt_s == ST_WRITE)) begin
            daddr_nxt_s = addr_sel_s;
        end else begin
            daddr_nxt_s = daddr_r;
        end
        if (state_nxt_s == ST_WRITE) begin
            dstore_nxt_s = store_sel_s;
        end else begin
            dstore_nxt_s = dstore_r;
        end
        case (state_r)
            ST_IDLE: begin
                // Only a failed SC goes straight to RESP from IDLE.
                if (state_nxt_s == ST_RESP) begin
                    dmemload_nxt_s = WORD_ZERO;
                end else begin
                    dmemload_nxt_s = dmemload_r;
                end
            end
            ST_READ: begin
                if (!dwait) begin
                    dmemload_nxt_s = dload;
                end else begin
                    dmemload_nxt_s = dmemload_r;
                end
            end
            ST_WRITE: begin
                if (!dwait) begin
                    dmemload_nxt_s = sc_flag_r ? WORD_ONE : WORD_ZERO;
                end else begin
                    dmemload_nxt_s = dmemload_r;
                end
            end
            default: begin
                dmemload_nxt_s = dmemload_r;
            end
        endcase
    end

    // Output registers; reset drops the strobes immediately.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            dhit_r     <= 1'b0;
            dmemload_r <= {WORD_W{1'b0}};
            dren_r     <= 1'b0;
            dwen_r     <= 1'b0;
            daddr_r    <= {ADDR_W{1'b0}};
            dstore_r   <= {WORD_W{1'b0}};
        end else begin
            dhit_r     <= dhit_nxt_s;
            dmemload_r <= dmemload_nxt_s;
            dren_r     <= dren_nxt_s;
            dwen_r     <= dwen_nxt_s;
            daddr_r    <= daddr_nxt_s;
            dstore_r   <= dstore_nxt_s;
        end
    end

    // Link update: LL completion sets it, then stores, snoops and halt may clear it.
    always_comb begin
        ll_done_s    = (state_r == ST_READ) && !dwait && req_atomic_r;
        store_kill_s = 1'b0;
        if (state_r == ST_IDLE && req_wr_s) begin
            if (datomic) begin
                store_kill_s = sc_ok_s;
            end else begin
                store_kill_s = word_match(dmemaddr, link_addr_r);
            end
        end else begin
            store_kill_s = 1'b0;
        end

        link_valid_nxt_s = link_valid_r;
        link_addr_nxt_s  = link_addr_r;
        if (ll_done_s) begin
            link_valid_nxt_s = 1'b1;
            link_addr_nxt_s  = req_addr_r;
        end else begin
            link_addr_nxt_s  = link_addr_r;
        end
        // Invalidations are checked against the post-update address so a
        // snoop coinciding with LL completion still kills the new reservation.
        if (store_kill_s || halt || (ccinv && word_match(ccsnoopaddr, link_addr_nxt_s))) begin
            link_valid_nxt_s = 1'b0;
        end else begin
            link_valid_nxt_s = link_valid_nxt_s;
        end
    end

    // Link register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            link_valid_r <= 1'b0;
            link_addr_r  <= {ADDR_W{1'b0}};
        end else begin
            link_valid_r <= link_valid_nxt_s;
            link_addr_r  <= link_addr_nxt_s;
        end
    end

    assign dhit     = dhit_r;
    assign dmemload = dmemload_r;
    assign dREN     = dren_r;
    assign dWEN     = dwen_r;
    assign daddr    = daddr_r;
    assign dstore   = dstore_r;

endmodule

// File: tb/tb_dmem_atomic_responder.sv
// Self-checking bench for dmem_atomic_responder: directed LL/SC scenarios and
// randomized traffic against a transaction-level reference model.
module tb_dmem_atomic_responder;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        dmemREN, dmemWEN, datomic;
    logic [31:0] dmemaddr, dmemstore;
    logic        dhit;
    logic [31:0] dmemload;
    logic        dREN, dWEN;
    logic [31:0] daddr, dstore;
    logic [31:0] dload;
    logic        dwait;
    logic        ccinv;
    logic [31:0] ccsnoopaddr;
    logic        halt;

    dmem_atomic_responder #(.ADDR_W(32), .WORD_W(32)) dut (
        .CLK(CLK), .nRST(nRST),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .datomic(datomic),
        .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .dhit(dhit), .dmemload(dmemload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dwait(dwait),
        .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr), .halt(halt)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference link: reservation valid flag and reserved word address.
    bit          m_valid = 1'b0;
    logic [29:0] m_word  = 30'd0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // One datapath request with its memory handshake; cc_end/halt_end fire on
    // the cycle the memory access completes.
    task automatic do_req(input bit rd, input bit wr, input bit at,
                          input logic [31:0] addr, input logic [31:0] store,
                          input logic [31:0] rdata, input int nwait,
                          input bit cc_end, input bit halt_end, input logic [31:0] cc_addr);
        bit          exp_rd = 1'b0;
        bit          exp_wr = 1'b0;
        logic [31:0] exp_load;
        int          exp_lat;
        int          c = 0, rc = 0, wc = 0, lat = 0;
        bit          got = 1'b0;
        bit          addr_ok = 1'b1;
        logic [31:0] load_seen = 32'd0;

        // Reference model of the transaction.
        if (rd) begin
            exp_rd   = 1'b1;
            exp_load = rdata;
        end else if (!at) begin
            exp_wr   = 1'b1;
            exp_load = 32'd0;
            if (m_word == addr[31:2]) m_valid = 1'b0;
        end else if (m_valid && m_word == addr[31:2]) begin
            exp_wr   = 1'b1;
            exp_load = 32'd1;
            m_valid  = 1'b0;
        end else begin
            exp_load = 32'd0;
        end
        exp_lat = (exp_rd || exp_wr) ? (3 + nwait) : 2;
        if (rd && at) begin
            m_word  = addr[31:2];
            m_valid = !(halt_end || (cc_end && cc_addr[31:2] == addr[31:2]));
        end

        @(negedge CLK);
        dmemREN   = rd;
        dmemWEN   = wr;
        datomic   = at;
        dmemaddr  = addr;
        dmemstore = store;
        dload     = rdata;
        dwait     = 1'b1;
        while (!got && c < 40) begin
            c++;
            ccinv = 1'b0;
            halt  = 1'b0;
            if (dhit) begin
                got       = 1'b1;
                lat       = c;
                load_seen = dmemload;
            end else begin
                if (dREN) begin
                    rc++;
                    if (daddr !== addr) addr_ok = 1'b0;
                end
                if (dWEN) begin
                    wc++;
                    if (daddr !== addr || dstore !== store) addr_ok = 1'b0;
                end
                if (dREN || dWEN) begin
                    dwait = ((rc + wc) <= nwait);
                    if (!dwait) begin
                        ccinv       = cc_end;
                        ccsnoopaddr = cc_addr;
                        halt        = halt_end;
                    end
                end
            end
            if (!got) @(negedge CLK);
        end
        if (!got) begin
            check_eq("timeout", 32'd0, 32'd1);
        end else begin
            check_eq("latency", lat, exp_lat);
            check_eq("dREN_cycles", rc, exp_rd ? (nwait + 1) : 0);
            check_eq("dWEN_cycles", wc, exp_wr ? (nwait + 1) : 0);
            check_eq("dmemload", load_seen, exp_load);
            check_eq("addr_store", {31'd0, addr_ok}, 32'd1);
            @(posedge CLK);
            #1;
            dmemREN = 1'b0;
            dmemWEN = 1'b0;
            datomic = 1'b0;
            ccinv   = 1'b0;
            halt    = 1'b0;
            @(negedge CLK);
            check_eq("dhit_one_cycle", {31'd0, dhit}, 32'd0);
            check_eq("dmemload_hold", dmemload, exp_load);
        end
    endtask

    // Idle-time snoop and/or halt.
    task automatic gap(input bit cc, input bit hlt, input logic [31:0] a);
        @(negedge CLK);
        ccinv       = cc;
        ccsnoopaddr = a;
        halt        = hlt;
        if (hlt) m_valid = 1'b0;
        if (cc && a[31:2] == m_word) m_valid = 1'b0;
        @(negedge CLK);
        ccinv = 1'b0;
        halt  = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_dhit"}, {31'd0, dhit}, 32'd0);
        check_eq({tag, "_dREN"}, {31'd0, dREN}, 32'd0);
        check_eq({tag, "_dWEN"}, {31'd0, dWEN}, 32'd0);
        check_eq({tag, "_daddr"}, daddr, 32'd0);
        check_eq({tag, "_dstore"}, dstore, 32'd0);
        check_eq({tag, "_dmemload"}, dmemload, 32'd0);
    endtask

    logic [31:0] pool [4] = '{32'h100, 32'h104, 32'h200, 32'h300};

    initial begin
        int hits_seen;
        nRST = 1'b0;
        dmemREN = 1'b0; dmemWEN = 1'b0; datomic = 1'b0;
        dmemaddr = 32'd0; dmemstore = 32'd0; dload = 32'd0; dwait = 1'b0;
        ccinv = 1'b0; ccsnoopaddr = 32'd0; halt = 1'b0;
        #12;
        check_outputs_zero("reset");
        @(negedge CLK);
        nRST = 1'b1;

        // LW with two wait states.
        do_req(1, 0, 0, 32'h100, 32'h0, 32'hDEADBEEF, 2, 0, 0, 32'h0);
        // LL then successful SC, then a second SC that must fail.
        do_req(1, 0, 1, 32'h200, 32'h0, 32'h11111111, 0, 0, 0, 32'h0);
        do_req(0, 1, 1, 32'h200, 32'h5, 32'h0, 0, 0, 0, 32'h0);
        do_req(0, 1, 1, 32'h200, 32'h6, 32'h0, 0, 0, 0, 32'h0);
        // LL, SW to same word, SC fails.
        do_req(1, 0, 1, 32'h200, 32'h0, 32'h22222222, 1, 0, 0, 32'h0);
        do_req(0, 1, 0, 32'h200, 32'h77, 32'h0, 1, 0, 0, 32'h0);
        do_req(0, 1, 1, 32'h200, 32'h8, 32'h0, 0, 0, 0, 32'h0);
        // Snoop to same word kills the link; snoop to next word does not.
        do_req(1, 0, 1, 32'h300, 32'h0, 32'h3, 0, 0, 0, 32'h0);
        gap(1, 0, 32'h302);
        do_req(0, 1, 1, 32'h300, 32'h9, 32'h0, 0, 0, 0, 32'h0);
        do_req(1, 0, 1, 32'h300, 32'h0, 32'h3, 0, 0, 0, 32'h0);
        gap(1, 0, 32'h304);
        do_req(0, 1, 1, 32'h300, 32'hA, 32'h0, 1, 0, 0, 32'h0);
        // Plain SW to another word keeps the link.
        do_req(1, 0, 1, 32'h100, 32'h0, 32'h4, 0, 0, 0, 32'h0);
        do_req(0, 1, 0, 32'h200, 32'hB, 32'h0, 0, 0, 0, 32'h0);
        do_req(0, 1, 1, 32'h101, 32'hC, 32'h0, 0, 0, 0, 32'h0);
        // LL completion coinciding with snoop or halt.
        do_req(1, 0, 1, 32'h200, 32'h0, 32'h5, 2, 1, 0, 32'h203);
        do_req(0, 1, 1, 32'h200, 32'hD, 32'h0, 0, 0, 0, 32'h0);
        do_req(1, 0, 1, 32'h200, 32'h0, 32'h6, 1, 0, 1, 32'h0);
        do_req(0, 1, 1, 32'h200, 32'hE, 32'h0, 0, 0, 0, 32'h0);
        // Read and write together: read wins.
        do_req(1, 1, 0, 32'h104, 32'hF, 32'hCAFEF00D, 1, 0, 0, 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 60; i++) begin
            int          kind;
            logic [31:0] a;
            kind = $urandom_range(0, 3);
            a    = pool[$urandom_range(0, 3)] + 32'($urandom_range(0, 3));
            case (kind)
                0: do_req(1, 0, 0, a, 32'h0, $urandom, $urandom_range(0, 3), 0, 0, 32'h0);
                1: do_req(1, 0, 1, a, 32'h0, $urandom, $urandom_range(0, 3),
                          ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                          pool[$urandom_range(0, 3)]);
                2: do_req(0, 1, 0, a, $urandom, 32'h0, $urandom_range(0, 3), 0, 0, 32'h0);
                default: do_req(0, 1, 1, a, $urandom, 32'h0, $urandom_range(0, 3), 0, 0, 32'h0);
            endcase
            if ($urandom_range(0, 3) == 0)
                gap($urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0, pool[$urandom_range(0, 3)]);
        end

        // Reset in the middle of a read (read+write request) loses the link.
        do_req(1, 0, 1, 32'h400, 32'h0, 32'h1234, 0, 0, 0, 32'h0);
        @(negedge CLK);
        dmemREN = 1'b1; dmemWEN = 1'b1; datomic = 1'b0;
        dmemaddr = 32'h500; dmemstore = 32'h55; dwait = 1'b1;
        @(negedge CLK);
        check_eq("midrd_dREN", {31'd0, dREN}, 32'd1);
        check_eq("midrd_dWEN", {31'd0, dWEN}, 32'd0);
        @(negedge CLK);
        nRST = 1'b0;
        #1;
        check_outputs_zero("midrst");
        dmemREN = 1'b0; dmemWEN = 1'b0; dwait = 1'b0;
        m_valid = 1'b0;
        hits_seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            if (k == 1) nRST = 1'b1;
            if (dhit) hits_seen++;
        end
        check_eq("midrst_no_dhit", hits_seen, 0);
        do_req(0, 1, 1, 32'h400, 32'h99, 32'h0, 0, 0, 0, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
